// File: rtl/pacman_input_pkg.sv
// Shared constants for the Pac-Man button front end.
// Direction codes, button indices and command FSM states.
package pacman_input_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_PAUSE = 4;
    localparam int N_CH      = 5;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

endpackage

// File: rtl/sampled_edge_detector.sv
// Tick-enabled 3-bit sampler with a one-clock rising-edge press pulse.
// The press is qualified by the delayed tick so it lasts exactly one clock.
module sampled_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic in,
    output logic press
);

    logic [2:0] sh;
    logic       tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= 3'b000;
            tick_d <= 1'b0;
        end else begin
            tick_d <= sample_en;
            if (sample_en) begin
                sh <= {in, sh[2:1]};
            end
        end
    end

    assign press = tick_d & sh[1] & ~sh[0];

endmodule

// File: rtl/direction_input_controller.sv
// Pac-Man button front end: sample prescaler, edge detection, round-robin
// arbitration and a one-deep buffered valid/ready direction channel.
module direction_input_controller
    import pacman_input_pkg::*;
#(
    parameter int SAMPLE_DIV = 500000,
    parameter int CNT_W      = $clog2(SAMPLE_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       pause_raw,
    output logic       sample_tick,
    output logic [1:0] dir_out,
    output logic       dir_valid,
    input  logic       dir_ready,
    output logic       paused,
    output logic       overrun
);

    logic [CNT_W-1:0] cnt;
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  press;
    logic [1:0]       state;
    logic [1:0]       next_dir;
    logic [1:0]       last_grant;
    logic [1:0]       idx;
    logic [1:0]       gdir;
    logic             grant;
    logic             paused_nxt;
    logic             xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (cnt == CNT_W'(SAMPLE_DIV - 1));
            if (cnt == CNT_W'(SAMPLE_DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign raw = {pause_raw, btn_raw};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sampled_edge_detector u_det (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (sample_tick),
            .in        (raw[g]),
            .press     (press[g])
        );
    end

    // Pause toggles first; directions see the post-toggle pause value.
    assign paused_nxt = paused ^ press[BTN_PAUSE];

    always_comb begin
        grant = 1'b0;
        gdir  = last_grant;
        idx   = last_grant;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!grant && press[idx]) begin
                grant = 1'b1;
                gdir  = idx;
            end
        end
        if (paused_nxt) begin
            grant = 1'b0;
        end
    end

    assign dir_valid = (state == ST_HOLD) || (state == ST_FULL);
    assign xfer      = dir_valid & dir_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dir_out    <= DIR_UP;
            next_dir   <= DIR_UP;
            last_grant <= DIR_RIGHT;
            paused     <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            paused <= paused_nxt;
            if (grant) begin
                last_grant <= gdir;
            end
            unique case (state)
                ST_IDLE: begin
                    if (grant) begin
                        dir_out <= gdir;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (xfer) begin
                        if (grant) dir_out <= gdir;
                        else       state   <= ST_IDLE;
                    end else if (grant) begin
                        next_dir <= gdir;
                        state    <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (xfer) begin
                        dir_out <= next_dir;
                        if (grant) next_dir <= gdir;
                        else       state    <= ST_HOLD;
                    end else if (grant) begin
                        // Newest command wins the buffer slot.
                        next_dir <= gdir;
                        overrun  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
